// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: FIFO of {pc, pc+4, instruction}, first-word-fall-through.
// Latency: one cycle from push to visibility on out_*, with no input-to-output bypass.
// Backpressure: stall_out is high while full and comes only from registered occupancy.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_pc_plus_4,
    input  logic [31:0]                in_instruction,
    output logic                       stall_out,
    input  logic                       flush_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc_plus_4,
    output logic [31:0]                out_instruction,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
        logic [31:0] instruction;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid && !full;
    assign pop   = !empty && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush_in) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never reset; the empty check below keeps stale entries off the outputs.
    always_ff @(posedge clk) begin
        if (push && !flush_in && !reset)
            mem[wr_ptr] <= '{pc: in_pc, pc_plus_4: in_pc_plus_4, instruction: in_instruction};
    end

    always_comb begin
        head = mem[rd_ptr];
        if (empty) begin
            head.pc          = '0;
            head.pc_plus_4   = '0;
            head.instruction = NOP_INSTR;
        end
    end

    assign out_valid       = !empty;
    assign out_pc          = head.pc;
    assign out_pc_plus_4   = head.pc_plus_4;
    assign out_instruction = head.instruction;
    assign stall_out       = full;
    assign count           = count_q;

endmodule
